// File: rtl/spi_slave_if.sv
// Pin and user-side bundle for the SPI mode-0 slave.
// The slave modport is the DUT view; the master modport is the host/bench view.
interface spi_slave_if;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       busy;
  logic       overrun;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_load, rx_ack,
    output miso, tx_ready, rx_data, rx_valid, busy, overrun
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_load, rx_ack,
    input  miso, tx_ready, rx_data, rx_valid, busy, overrun
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by clk: sclk/cs/mosi are synchronized and
// edge-detected, then one byte is shifted in and out per eight sclk cycles.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] FLUSH_DONE = 3'(SYNC_STAGES + 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic [2:0]             r_flush_cnt;
  logic                   r_cs_armed;
  logic [7:0]             r_tx_buf;
  logic                   r_tx_pending;
  logic [7:0]             r_tx_shift;
  logic [7:0]             r_rx_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_miso;
  logic [7:0]             r_rx_data;
  logic                   r_rx_valid;
  logic                   r_overrun;

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_enter_shift;
  logic [7:0] w_rx_byte;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  // A cs fall only counts once a genuine high has been seen since reset,
  // so cs held low through reset release cannot start a transfer.
  assign w_cs_fall   = ~w_cs_s & r_cs_d & r_cs_armed;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_enter_shift = (r_state == IDLE) && w_cs_fall;
  assign w_rx_byte   = {r_rx_shift[6:0], w_mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_flush_cnt <= 3'd0;
      r_cs_armed  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      if (r_flush_cnt != FLUSH_DONE) begin
        r_flush_cnt <= r_flush_cnt + 3'd1;
      end else if (w_cs_s) begin
        r_cs_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_next = SHIFT;
      SHIFT:   if (w_cs_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_buf     <= 8'h00;
      r_tx_pending <= 1'b0;
      r_tx_shift   <= 8'h00;
      r_rx_shift   <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_miso       <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (bus.tx_load) begin
        r_tx_buf     <= bus.tx_data;
        r_tx_pending <= 1'b1;
      end
      if (bus.rx_ack) begin
        r_rx_valid <= 1'b0;
      end
      if (w_enter_shift) begin
        r_tx_shift <= r_tx_buf;
        r_miso     <= r_tx_buf[7];
        r_bit_cnt  <= 3'd0;
        if (!bus.tx_load) r_tx_pending <= 1'b0;
      end else if (r_state == SHIFT) begin
        if (w_cs_rise) begin
          r_miso <= 1'b0;
        end else if (w_sclk_rise) begin
          r_rx_shift <= w_rx_byte;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_rx_data  <= w_rx_byte;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !bus.rx_ack) r_overrun <= 1'b1;
          end
        end else if (w_sclk_fall) begin
          if (r_bit_cnt != 3'd0) begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            r_miso     <= r_tx_shift[6];
          end else begin
            // Byte boundary: a buffer written in this same cycle waits for the next byte.
            r_tx_shift <= r_tx_buf;
            r_miso     <= r_tx_buf[7];
            if (!bus.tx_load) r_tx_pending <= 1'b0;
          end
        end
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign bus.miso     = r_miso;
  assign bus.tx_ready = ~r_tx_pending;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = (r_state == SHIFT);
  assign bus.overrun  = r_overrun;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in each synchronizer on sclk, cs and mosi (legal range 2-3).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge; one clock domain only.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sclk  input  1  SPI clock from the master; asynchronous to clk.
REQ-005 SHALL have port cs  input  1  chip select, active low; asynchronous to clk.
REQ-006 SHALL have port mosi  input  1  serial data from the master, MSB first.
REQ-007 SHALL have port miso  output  1  serial data to the master, MSB first; registered.
REQ-008 SHALL have port tx_data  input  8  next byte to transmit.
REQ-009 SHALL have port tx_load  input  1  one-cycle strobe that writes tx_data into the transmit buffer.
REQ-010 SHALL have port tx_ready  output  1  high when the transmit buffer has been consumed and may be written.
REQ-011 SHALL have port rx_data  output  8  last complete received byte.
REQ-012 SHALL have port rx_valid  output  1  high while rx_data holds an unacknowledged byte.
REQ-013 SHALL have port rx_ack  input  1  one-cycle strobe that clears rx_valid.
REQ-014 SHALL have port busy  output  1  high while the synchronized cs is low.
REQ-015 SHALL have port overrun  output  1  sticky error flag: a byte completed while rx_valid was high.

Function
REQ-016 SHALL use SPI mode 0: sample mosi on sclk rising edges and change miso on sclk falling edges.
REQ-017 SHALL pass sclk, cs and mosi through SYNC_STAGES-deep synchronizers, then detect edges by comparing against one further registered copy.
REQ-018 SHALL operate correctly only when the clk frequency is at least 8x the sclk frequency; this is a system requirement on the integrator.
REQ-019 SHALL implement the FSM states IDLE and SHIFT: IDLE->SHIFT on a synchronized cs falling edge; SHIFT->IDLE on a synchronized cs rising edge; busy = (state == SHIFT).
REQ-020 SHALL, on entering SHIFT, copy tx_buf into tx_shift, drive miso with tx_buf[7] on the next cycle, clear bit_cnt to 0, and clear tx_pending.
REQ-021 SHALL, on each detected sclk rising edge in SHIFT, shift the synchronized mosi into the LSB of rx_shift and increment bit_cnt (3-bit, wrapping 7->0).
REQ-022 SHALL, on the rising edge that takes bit_cnt from 7 to 0, perform all of the following:
  - load rx_data with the completed byte;
  - set rx_valid;
  - if rx_valid was already high and rx_ack is not asserted in that cycle, set overrun.
REQ-023 SHALL, on each detected sclk falling edge in SHIFT:
  - if bit_cnt != 0, shift tx_shift left and drive miso with the new MSB;
  - if bit_cnt == 0 (byte boundary), reload tx_shift from tx_buf, drive miso with tx_buf[7], and clear tx_pending.
REQ-024 SHALL, when tx_load is asserted, write tx_data into tx_buf and set tx_pending; tx_ready = !tx_pending.
REQ-025 SHALL accept tx_load even while tx_ready is low, overwriting tx_buf; if tx_load coincides with a buffer copy, the copy takes the old tx_buf value and tx_pending ends set.
REQ-026 SHALL, when no new tx_load has occurred, retransmit the current tx_buf value at the next byte boundary.
REQ-027 SHALL clear rx_valid on rx_ack; if rx_ack coincides with a byte completion, rx_valid ends set and overrun is unchanged.
REQ-028 SHALL, when cs rises mid-byte (bit_cnt != 0), discard the partial byte (no rx_valid, rx_data unchanged) and return to IDLE.
REQ-029 SHALL ignore sclk edges while in IDLE.
REQ-030 SHALL drive miso to 0 in IDLE.
REQ-031 SHALL have a latency from a pin edge to its registered effect of SYNC_STAGES+1 clk cycles.

Reset
REQ-032 SHALL, while rst is high at a clk edge, set the following, overriding all other inputs including a mid-transfer cs low:
  - state = IDLE; miso = 0; rx_data = 0x00; rx_valid = 0; overrun = 0; busy = 0;
  - tx_buf = 0x00; tx_pending = 0 (so tx_ready = 1); bit_cnt = 0; all shift and synchronizer registers = 0, except the cs synchronizer, which resets to 1.
REQ-033 SHALL, when cs is low as rst releases, not treat it as a cs falling edge; a transfer starts only after cs goes high and then low again.

Verification
REQ-034 SHALL pass: tx_load 0x3C, cs low, master shifts 0xA5 -> miso bits sampled 0,0,1,1,1,1,0,0; rx_data=0xA5; rx_valid=1; tx_ready=1 after cs fall.
REQ-035 SHALL pass: two back-to-back bytes 0x01 then 0x80 with no rx_ack -> rx_data=0x80; overrun=1.
REQ-036 SHALL pass: rx_ack in the same cycle as the second byte's completion -> rx_valid=1; overrun=0.
REQ-037 SHALL pass: cs rises after 5 bits -> rx_valid stays 0; rx_data unchanged; state=IDLE; miso=0.
REQ-038 SHALL pass: rst pulsed mid-byte with cs held low -> all outputs at reset values; no transfer starts until cs rises and falls again.
REQ-039 SHALL pass: no tx_load before a two-byte transfer after reset -> miso outputs 0x00 for both bytes.
